// File: rtl/booth_wallace_pkg.sv
// Shared widths and types for the Booth-4 / Wallace 16x16 multiplier datapath.
package booth_wallace_pkg;

  localparam int PROD_W = 32;
  localparam int SEG_W  = 16;

  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [SEG_W-1:0]  seg_t;

endpackage

// File: rtl/cpa_segment.sv
// Ripple-carry adder segment built from half_adder / full_adder cells.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b;
  assign cout = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic w_s0, w_c0, w_c1;

  half_adder u_ha0 (.a(a),    .b(b),   .sum(w_s0), .cout(w_c0));
  half_adder u_ha1 (.a(w_s0), .b(cin), .sum(sum),  .cout(w_c1));

  assign cout = w_c0 | w_c1;
endmodule

module cpa_segment #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (w_c[i]),
      .sum (sum[i]),
      .cout(w_c[i+1])
    );
  end

  assign cout = w_c[W];
endmodule

// File: rtl/wallace_final_cpa.sv
// Two-stage pipelined final carry-propagate adder of the multiplier tree.
// Optional carry-out port and register enabled by defining CPA_COUT_EN.
module wallace_final_cpa #(
  parameter int WIDTH = booth_wallace_pkg::PROD_W,
  parameter int SEG_W = booth_wallace_pkg::SEG_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_row,
  input  logic [WIDTH-1:0] carry_row,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product
`ifdef CPA_COUT_EN
  ,output logic            cout
`endif
);
  import booth_wallace_pkg::*;

  localparam int HI_W = WIDTH - SEG_W;

  logic             r_s1_valid;
  logic             r_s2_valid;
  logic [SEG_W-1:0] r_s1_lo;
  logic             r_s1_cmid;
  logic [HI_W-1:0]  r_s1_a_hi;
  logic [HI_W-1:0]  r_s1_b_hi;
  logic [WIDTH-1:0] r_prod;

  logic             w_s1_en;
  logic             w_s2_en;
  logic [SEG_W-1:0] w_lo_sum;
  logic             w_lo_cout;
  logic [HI_W-1:0]  w_hi_sum;

  // in_ready depends combinationally on out_ready so a full pipe can stream.
  assign w_s2_en  = !r_s2_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign in_ready = w_s1_en;

  cpa_segment #(.W(SEG_W)) u_seg_lo (
    .a   (sum_row[SEG_W-1:0]),
    .b   (carry_row[SEG_W-1:0]),
    .cin (1'b0),
    .sum (w_lo_sum),
    .cout(w_lo_cout)
  );

`ifdef CPA_COUT_EN
  logic w_hi_cout;
  logic r_cout;

  cpa_segment #(.W(HI_W)) u_seg_hi (
    .a   (r_s1_a_hi),
    .b   (r_s1_b_hi),
    .cin (r_s1_cmid),
    .sum (w_hi_sum),
    .cout(w_hi_cout)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cout <= 1'b0;
    end else if (w_s2_en && r_s1_valid) begin
      r_cout <= w_hi_cout;
    end
  end

  assign cout = r_cout;
`else
  cpa_segment #(.W(HI_W)) u_seg_hi (
    .a   (r_s1_a_hi),
    .b   (r_s1_b_hi),
    .cin (r_s1_cmid),
    .sum (w_hi_sum),
    .cout()
  );
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_en) r_s1_valid <= in_valid;
      if (w_s2_en) r_s2_valid <= r_s1_valid;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1_lo   <= '0;
      r_s1_cmid <= 1'b0;
      r_s1_a_hi <= '0;
      r_s1_b_hi <= '0;
    end else if (w_s1_en && in_valid) begin
      r_s1_lo   <= w_lo_sum;
      r_s1_cmid <= w_lo_cout;
      r_s1_a_hi <= sum_row[WIDTH-1:SEG_W];
      r_s1_b_hi <= carry_row[WIDTH-1:SEG_W];
    end
  end

  // Data holds while stalled so product stays stable under backpressure.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_prod <= '0;
    end else if (w_s2_en && r_s1_valid) begin
      r_prod <= {w_hi_sum, r_s1_lo};
    end
  end

  assign out_valid = r_s2_valid;
  assign product   = r_prod;

endmodule

// File: tb/tb_wallace_final_cpa.sv
// Directed and random checks of the pipelined final CPA against a queue model.
module tb_wallace_final_cpa;
  import booth_wallace_pkg::*;

  logic  sys_clk = 1'b0;
  logic  sys_rst_n;
  logic  in_valid;
  logic  in_ready;
  prod_t sum_row;
  prod_t carry_row;
  logic  out_valid;
  logic  out_ready;
  prod_t product;
`ifdef CPA_COUT_EN
  logic  cout;
`endif

  wallace_final_cpa #(.WIDTH(32), .SEG_W(16)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum_row  (sum_row),
    .carry_row(carry_row),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product)
`ifdef CPA_COUT_EN
    ,.cout    (cout)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_bad = 0;
  int n_out = 0;

  logic [32:0] exp_q[$];

  logic  g_ovalid, g_iready, g_acc, g_emit;
  prod_t g_prod;
  logic  pend = 1'b0;
  prod_t pend_s, pend_c;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, model the rising-edge transfers.
  task automatic cycle(input logic v, input prod_t s, input prod_t c, input logic ordy);
    logic [32:0] e;
    @(negedge sys_clk);
    if (pend) begin
      chk("proto_hold", {v, s, c}, {1'b1, pend_s, pend_c});
    end
    in_valid  = v;
    sum_row   = s;
    carry_row = c;
    out_ready = ordy;
    #1;
    g_ovalid = out_valid;
    g_iready = in_ready;
    g_prod   = product;
    g_acc    = v && in_ready;
    g_emit   = out_valid && ordy;
    if (g_emit) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("product", product, e[31:0]);
`ifdef CPA_COUT_EN
        chk("cout", cout, e[32]);
`endif
        n_out++;
      end
    end
    if (g_acc) exp_q.push_back({1'b0, s} + {1'b0, c});
    pend   = v && !g_acc;
    pend_s = s;
    pend_c = c;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, pending=%0d", exp_q.size());
    $fatal(1);
  end

  initial begin
    int    cnt, sent, budget, base;
    prod_t held, rs, rc;
    logic  offer;

    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    sum_row   = '0;
    carry_row = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_product", product, 0);
`ifdef CPA_COUT_EN
    chk("rst_cout", cout, 0);
`endif
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Cross-segment carry and latency
    cycle(1, 32'h0000_FFFF, 32'h0000_0001, 1);
    chk("t1_accept", g_acc, 1);
    cycle(0, '0, '0, 1);
    chk("t1_lat_early", g_ovalid, 0);
    cycle(0, '0, '0, 1);
    chk("t1_lat_valid", g_ovalid, 1);
    chk("t1_product", g_prod, 32'h0001_0000);

    // Wrap-around
    cycle(1, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    cycle(0, '0, '0, 1);
    cycle(0, '0, '0, 1);
    chk("t2_valid", g_ovalid, 1);
    chk("t2_product", g_prod, 32'h0000_0000);
`ifdef CPA_COUT_EN
    chk("t2_cout", cout, 1);
`endif

    // Back-to-back: results on four consecutive cycles
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: cycle(1, 32'h1234_5678, 32'h1111_1111, 1);
        1: cycle(1, 32'h8000_8000, 32'h8000_8000, 1);
        2: cycle(1, 32'h0F0F_F0F0, 32'h00FF_0F10, 1);
        3: cycle(1, 32'h7FFF_FFFF, 32'h0000_0001, 1);
        default: cycle(0, '0, '0, 1);
      endcase
      if (i < 4) chk("t3_in_ready", g_iready, 1);
      chk("t3_emit_slot", g_emit, (i >= 2 && i <= 5));
    end

    // Backpressure: three items offered with out_ready low for six cycles
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: cycle(1, 32'h0000_0100, 32'h0000_0023, 0);
        1: cycle(1, 32'hABCD_0000, 32'h0000_FFFF, 0);
        default: cycle(1, 32'h0001_8000, 32'h0000_8000, 0);
      endcase
      if (g_acc) cnt++;
      if (i == 2) held = g_prod;
      if (i >= 2) begin
        chk("t4_in_ready_low", g_iready, 0);
        chk("t4_hold_product", g_prod, held);
      end
    end
    chk("t4_accepted", cnt, 2);
    chk("t4_held_value", held, 32'h0000_0123);
    base   = n_out;
    budget = 0;
    do begin
      cycle(1, 32'h0001_8000, 32'h0000_8000, 1);
      budget++;
    end while (!g_acc && budget < 10);
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      cycle(0, '0, '0, 1);
      budget++;
    end
    chk("t4_delivered", n_out - base, 3);

    // Reset with both stages full
    cycle(1, 32'h0000_0005, 32'h0000_0006, 0);
    cycle(1, 32'h0000_0007, 32'h0000_0008, 0);
    cycle(0, '0, '0, 0);
    chk("t5_full", g_ovalid, 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_product", product, 0);
    exp_q.delete();
    pend = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    cycle(1, 32'h0000_0AAA, 32'h0000_0555, 1);
    cycle(0, '0, '0, 1);
    chk("t5_no_stale", g_ovalid, 0);
    cycle(0, '0, '0, 1);
    chk("t5_first_valid", g_ovalid, 1);
    chk("t5_first_product", g_prod, 32'h0000_0FFF);

    // Random rows with random backpressure
    base   = n_out;
    sent   = 0;
    budget = 0;
    offer  = 1'b0;
    rs     = '0;
    rc     = '0;
    while ((sent < 10000 || exp_q.size() > 0) && budget < 60000) begin
      if (!offer && sent < 10000 && $urandom_range(0, 3) != 0) begin
        offer = 1'b1;
        rs    = $urandom;
        rc    = $urandom;
      end
      cycle(offer, rs, rc, $urandom_range(0, 2) != 0);
      if (g_acc) begin
        offer = 1'b0;
        sent++;
      end
      budget++;
    end
    chk("t6_sent", sent, 10000);
    chk("t6_delivered", n_out - base, 10000);
    chk("t6_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
